md_unit: RTL and testbench

- Multiply/divide unit for the EX stage of the 5-stage MIPS pipeline; sits alongside the ALU.
- Consumes the forwarded operands (post-forwarding RS/RT, same values the ALU sees).
- Holds HI/LO; hi/lo feed the EX/MEM register for mfhi/mflo.
- Exposes busy so the stall controller can freeze IF/ID and flush ID/EX while an operation is in flight.

---
 rtl/md_unit.sv | 147 ++++++++++++++
 tb/tb_md_unit.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/md_unit.sv
// Multiply/divide unit for the EX stage: computes mult/div results on accept, holds them
// for a fixed latency, then commits to HI/LO. Also handles mthi/mtlo register writes.
module md_unit #(
  parameter int unsigned MultCycles = 5,
  parameter int unsigned DivCycles  = 10
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        start_i,
  input  logic [2:0]  md_op_i,
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  output logic        busy_o,
  output logic        done_o,
  output logic [31:0] hi_o,
  output logic [31:0] lo_o
);

  localparam int unsigned MaxCycles = (MultCycles > DivCycles) ? MultCycles : DivCycles;
  localparam int unsigned CntW      = $clog2(MaxCycles) + 1;
  localparam logic [CntW-1:0] MultLoad = CntW'(MultCycles - 1);
  localparam logic [CntW-1:0] DivLoad  = CntW'(DivCycles - 1);

  localparam logic [2:0] OpMult  = 3'b000;
  localparam logic [2:0] OpMultu = 3'b001;
  localparam logic [2:0] OpDiv   = 3'b010;
  localparam logic [2:0] OpDivu  = 3'b011;
  localparam logic [2:0] OpMthi  = 3'b100;
  localparam logic [2:0] OpMtlo  = 3'b101;

  typedef enum logic {StIdle, StRun} state_e;

  state_e          state_q;
  logic [CntW-1:0] count_q;
  logic [31:0]     pend_hi_q, pend_lo_q;
  logic            pend_we_q;
  logic [31:0]     hi_q, lo_q;
  logic            busy_q, done_q;

  logic        is_arith, is_div;
  logic [63:0] a_ext, b_ext, prod;
  logic        a_neg, b_neg;
  logic [31:0] a_mag, b_mag, div_den, quo_mag, rem_mag;
  logic [31:0] res_hi, res_lo;
  logic        res_we;

  assign is_arith = (md_op_i[2] == 1'b0);
  assign is_div   = md_op_i[1];

  always_comb begin
    a_ext   = 64'd0;
    b_ext   = 64'd0;
    prod    = 64'd0;
    a_neg   = 1'b0;
    b_neg   = 1'b0;
    a_mag   = a_i;
    b_mag   = b_i;
    div_den = 32'd1;
    quo_mag = 32'd0;
    rem_mag = 32'd0;
    res_hi  = 32'd0;
    res_lo  = 32'd0;
    res_we  = 1'b1;

    // Sign- or zero-extend to 64 bits so one multiplier covers both mult flavours.
    a_ext = (md_op_i == OpMult) ? {{32{a_i[31]}}, a_i} : {32'd0, a_i};
    b_ext = (md_op_i == OpMult) ? {{32{b_i[31]}}, b_i} : {32'd0, b_i};
    prod  = a_ext * b_ext;

    // Signed divide works on magnitudes; 0x80000000 keeps its bit pattern as magnitude 2^31.
    a_neg   = (md_op_i == OpDiv) && a_i[31];
    b_neg   = (md_op_i == OpDiv) && b_i[31];
    a_mag   = a_neg ? (~a_i + 32'd1) : a_i;
    b_mag   = b_neg ? (~b_i + 32'd1) : b_i;
    div_den = (b_mag == 32'd0) ? 32'd1 : b_mag;
    quo_mag = a_mag / div_den;
    rem_mag = a_mag % div_den;

    unique case (md_op_i)
      OpMult, OpMultu: begin
        res_hi = prod[63:32];
        res_lo = prod[31:0];
      end
      OpDiv, OpDivu: begin
        res_lo = (a_neg ^ b_neg) ? (~quo_mag + 32'd1) : quo_mag;
        res_hi = a_neg ? (~rem_mag + 32'd1) : rem_mag;
        // Divide by zero leaves HI/LO untouched at commit.
        res_we = (b_i != 32'd0);
      end
      default: res_we = 1'b0;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= StIdle;
      count_q   <= '0;
      pend_hi_q <= 32'd0;
      pend_lo_q <= 32'd0;
      pend_we_q <= 1'b0;
      hi_q      <= 32'd0;
      lo_q      <= 32'd0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (start_i) begin
            if (is_arith) begin
              pend_hi_q <= res_hi;
              pend_lo_q <= res_lo;
              pend_we_q <= res_we;
              count_q   <= is_div ? DivLoad : MultLoad;
              state_q   <= StRun;
              busy_q    <= 1'b1;
            end else if (md_op_i == OpMthi) begin
              hi_q <= a_i;
            end else if (md_op_i == OpMtlo) begin
              lo_q <= a_i;
            end
          end
        end
        StRun: begin
          if (count_q != '0) begin
            count_q <= count_q - CntW'(1);
          end else begin
            if (pend_we_q) begin
              hi_q <= pend_hi_q;
              lo_q <= pend_lo_q;
            end
            state_q <= StIdle;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign busy_o = busy_q;
  assign done_o = done_q;
  assign hi_o   = hi_q;
  assign lo_o   = lo_q;

endmodule

// File: tb/tb_md_unit.sv
// Self-checking bench for md_unit: directed cases plus random ops against a
// timeline-based reference model.
module tb_md_unit;

  localparam int unsigned MultN = 5;
  localparam int unsigned DivN  = 10;

  logic        clk, rst_ni, start;
  logic [2:0]  md_op;
  logic [31:0] a, b;
  logic        busy, done;
  logic [31:0] hi, lo;

  md_unit #(.MultCycles(MultN), .DivCycles(DivN)) dut (
    .clk_i  (clk),
    .rst_ni (rst_ni),
    .start_i(start),
    .md_op_i(md_op),
    .a_i    (a),
    .b_i    (b),
    .busy_o (busy),
    .done_o (done),
    .hi_o   (hi),
    .lo_o   (lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_total = 0;
  int n_bad   = 0;

  // Reference model: absolute commit time instead of a countdown.
  int          cyc = 0;
  bit          m_pending = 0;
  int          m_commit_at = 0;
  logic [31:0] m_hi = 0, m_lo = 0, m_phi = 0, m_plo = 0;
  bit          m_pwe = 0, m_done = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%08h exp=%08h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic ref_compute(input logic [2:0] op, input logic [31:0] x, input logic [31:0] y,
                             output logic [31:0] rh, output logic [31:0] rl, output bit we);
    int          sx, sy;
    longint      p, q, r;
    logic [63:0] pu;
    sx = x;
    sy = y;
    we = 1;
    rh = 0;
    rl = 0;
    case (op)
      3'd0: begin p = longint'(sx) * longint'(sy); pu = p; rh = pu[63:32]; rl = pu[31:0]; end
      3'd1: begin pu = 64'(x) * 64'(y); rh = pu[63:32]; rl = pu[31:0]; end
      3'd2: begin
        if (y == 0) we = 0;
        else begin
          q = longint'(sx) / longint'(sy);
          r = longint'(sx) % longint'(sy);
          pu = q; rl = pu[31:0];
          pu = r; rh = pu[31:0];
        end
      end
      default: begin
        if (y == 0) we = 0;
        else begin rl = x / y; rh = x % y; end
      end
    endcase
  endtask

  task automatic model_edge(input bit s, input logic [2:0] op, input logic [31:0] x,
                            input logic [31:0] y);
    cyc++;
    m_done = 0;
    if (m_pending) begin
      if (cyc == m_commit_at) begin
        if (m_pwe) begin m_hi = m_phi; m_lo = m_plo; end
        m_pending = 0;
        m_done = 1;
      end
    end else if (s) begin
      if (op <= 3'd3) begin
        ref_compute(op, x, y, m_phi, m_plo, m_pwe);
        m_pending = 1;
        m_commit_at = cyc + ((op >= 3'd2) ? DivN : MultN);
      end else if (op == 3'd4) m_hi = x;
      else if (op == 3'd5) m_lo = x;
    end
  endtask

  // Called at a negedge; returns at the following negedge after checking.
  task automatic cycle(input bit s, input logic [2:0] op, input logic [31:0] x,
                       input logic [31:0] y);
    start = s;
    md_op = op;
    a = x;
    b = y;
    @(posedge clk);
    model_edge(s, op, x, y);
    @(negedge clk);
    check_eq("busy", {31'd0, busy}, {31'd0, m_pending});
    check_eq("done", {31'd0, done}, {31'd0, m_done});
    check_eq("hi", hi, m_hi);
    check_eq("lo", lo, m_lo);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(0, 3'd0, $urandom, $urandom);
  endtask

  task automatic run_op(input logic [2:0] op, input logic [31:0] x, input logic [31:0] y);
    cycle(1, op, x, y);
    idle((op >= 3'd2) ? DivN : MultN);
  endtask

  function automatic logic [31:0] rnd_val();
    case ($urandom_range(0, 7))
      0: return 32'h0;
      1: return 32'h8000_0000;
      2: return 32'hFFFF_FFFF;
      3: return $urandom_range(0, 20);
      default: return $urandom;
    endcase
  endfunction

  initial begin
    #200000;
    $display("FAIL timeout: got=running exp=finished");
    $fatal(1, "timeout");
  end

  initial begin
    rst_ni = 1'b0;
    start = 0; md_op = 0; a = 0; b = 0;
    @(negedge clk);
    @(negedge clk);
    check_eq("rst_busy", {31'd0, busy}, 32'd0);
    check_eq("rst_done", {31'd0, done}, 32'd0);
    check_eq("rst_hi", hi, 32'd0);
    check_eq("rst_lo", lo, 32'd0);
    rst_ni = 1'b1;

    // mult / multu
    run_op(3'd0, 32'hFFFF_FFFD, 32'd5);
    check_eq("mult_hi", hi, 32'hFFFF_FFFF);
    check_eq("mult_lo", lo, 32'hFFFF_FFF1);
    run_op(3'd1, 32'hFFFF_FFFD, 32'd5);
    check_eq("multu_hi", hi, 32'h0000_0004);
    check_eq("multu_lo", lo, 32'hFFFF_FFF1);

    // div / divu / overflow case
    run_op(3'd2, 32'hFFFF_FFF9, 32'd2);
    check_eq("div_hi", hi, 32'hFFFF_FFFF);
    check_eq("div_lo", lo, 32'hFFFF_FFFD);
    run_op(3'd3, 32'd7, 32'd2);
    check_eq("divu_hi", hi, 32'd1);
    check_eq("divu_lo", lo, 32'd3);
    run_op(3'd2, 32'h8000_0000, 32'hFFFF_FFFF);
    check_eq("divov_hi", hi, 32'd0);
    check_eq("divov_lo", lo, 32'h8000_0000);

    // mthi/mtlo then divide by zero
    cycle(1, 3'd4, 32'h11, 32'd0);
    check_eq("mthi_busy", {31'd0, busy}, 32'd0);
    cycle(1, 3'd5, 32'h22, 32'd0);
    run_op(3'd3, 32'd99, 32'd0);
    check_eq("dz_hi", hi, 32'h11);
    check_eq("dz_lo", lo, 32'h22);

    // start while busy is ignored
    cycle(1, 3'd0, 32'd6, 32'd7);
    cycle(0, 3'd0, 32'd0, 32'd0);
    cycle(1, 3'd3, 32'd100, 32'd7);
    idle(DivN + 2);
    check_eq("ign_hi", hi, 32'd0);
    check_eq("ign_lo", lo, 32'd42);

    // back-to-back: new start in the cycle after commit
    cycle(1, 3'd0, 32'd3, 32'd4);
    idle(MultN);
    cycle(1, 3'd1, 32'd10, 32'd10);
    check_eq("b2b_mid_lo", lo, 32'd12);
    idle(MultN);
    check_eq("b2b_lo", lo, 32'd100);

    // asynchronous reset mid-operation
    run_op(3'd0, 32'hFFFF_FFFD, 32'd5);
    cycle(1, 3'd1, 32'd9, 32'd9);
    cycle(0, 3'd0, 32'd0, 32'd0);
    #2 rst_ni = 1'b0;
    #1;
    check_eq("arst_busy", {31'd0, busy}, 32'd0);
    check_eq("arst_hi", hi, 32'd0);
    check_eq("arst_lo", lo, 32'd0);
    m_pending = 0; m_hi = 0; m_lo = 0; m_done = 0;
    @(negedge clk);
    rst_ni = 1'b1;
    idle(MultN + 3);
    check_eq("arst_nocommit", lo, 32'd0);

    // random traffic, including reserved ops and starts while busy
    for (int i = 0; i < 600; i++) begin
      cycle(($urandom_range(0, 2) == 0), 3'($urandom_range(0, 7)), rnd_val(), rnd_val());
    end
    idle(DivN + 1);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
